// File: rtl/fp_addsub_sched.sv
// fp_addsub_sched: round-robin sequencer between two add/sub requesters and
// the shared single-precision add/sub datapath. Each accepted operation is
// launched, waited on for LAT cycles, and its result is returned on the owning
// requester's response channel.
// Optional feature macro: FP_SCHED_NAN_BYPASS_EN -- requests with a NaN
// operand skip the datapath and return the canonical quiet NaN one cycle later.
module fp_addsub_sched #(
  parameter int WIDTH = 32,
  parameter int LAT   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_r,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_r,
  output logic             dp_start,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  output logic             dp_op,
  input  logic [WIDTH-1:0] dp_r,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0]       CNT_INIT = 4'(LAT - 1);
  localparam logic [WIDTH-1:0] QNAN     = WIDTH'(32'h7FC0_0000);

  state_t           state;
  logic [3:0]       cnt;
  logic             last_grant;
  logic             owner;

  logic             grant;
  logic             fire;
  logic             bypass;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_op;

  // Exponent all ones with a non-zero fraction marks a NaN.
  function automatic logic is_nan(input logic [WIDTH-1:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Round-robin grant and request-side handshake; ready is held low in reset.
  always_comb begin
    grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
    req1_ready = rst_n && (state == IDLE) && req1_valid && grant;
    fire       = req0_ready || req1_ready;
    sel_a      = grant ? req1_a  : req0_a;
    sel_b      = grant ? req1_b  : req0_b;
    sel_op     = grant ? req1_op : req0_op;
`ifdef FP_SCHED_NAN_BYPASS_EN
    bypass     = is_nan(sel_a) || is_nan(sel_b);
`else
    bypass     = 1'b0;
`endif
  end

  // Sequencer: accept, launch, count down the datapath latency, respond.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      dp_start   <= 1'b0;
      dp_a       <= '0;
      dp_b       <= '0;
      dp_op      <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_r     <= '0;
      rsp1_r     <= '0;
      busy       <= 1'b0;
    end else begin
      dp_start <= 1'b0;
      case (state)
        IDLE: begin
          if (fire) begin
            owner      <= grant;
            last_grant <= grant;
            busy       <= 1'b1;
            if (bypass) begin
              // NaN short-cut: answer directly, datapath operands untouched.
              state <= RESP;
              if (grant) begin
                rsp1_r     <= QNAN;
                rsp1_valid <= 1'b1;
              end else begin
                rsp0_r     <= QNAN;
                rsp0_valid <= 1'b1;
              end
            end else begin
              state    <= ISSUE;
              dp_start <= 1'b1;
              dp_a     <= sel_a;
              dp_b     <= sel_b;
              dp_op    <= sel_op;
            end
          end
        end
        ISSUE: begin
          cnt   <= CNT_INIT;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
            if (owner) begin
              rsp1_r     <= dp_r;
              rsp1_valid <= 1'b1;
            end else begin
              rsp0_r     <= dp_r;
              rsp0_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          // Only the owning port's ready completes the response.
          if (owner ? rsp1_ready : rsp0_ready) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
